rename_ckpt: RTL and testbench

- Parametrised single-wide register-rename stage with a circular free-list FIFO, a physical-register ready table, and a multi-entry branch checkpoint stack.
- Sits between decode and dispatch/issue.
- Maps architectural source/destination registers to physical registers.
- Returns stale physical registers to the free list on in-order commit.
- Recovers RAT and free-list state on a branch mispredict.
- Supports up to NUM_CKPT unresolved branches.

---
 rtl/rename_ckpt.sv | 185 ++++++++++++++++++
 tb/tb_rename_ckpt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt.sv
// Single-wide register rename: RAT, circular free list, physical ready table and
// a branch checkpoint stack for mispredict recovery. Rename is combinational.
module rename_ckpt #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned NUM_CKPT  = 4,
    localparam int unsigned AW = $clog2(ARCH_REGS),
    localparam int unsigned PW = $clog2(PHYS_REGS),
    localparam int unsigned TW = $clog2(NUM_CKPT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          dec_valid_i,
    output logic          dec_ready_o,
    input  logic          dec_rs1_valid_i,
    input  logic          dec_rs2_valid_i,
    input  logic [AW-1:0] dec_rs1_i,
    input  logic [AW-1:0] dec_rs2_i,
    input  logic          dec_rd_valid_i,
    input  logic [AW-1:0] dec_rd_i,
    input  logic          dec_is_branch_i,
    output logic          ren_valid_o,
    output logic [PW-1:0] ren_rs1_p_o,
    output logic [PW-1:0] ren_rs2_p_o,
    output logic          ren_rs1_rdy_o,
    output logic          ren_rs2_rdy_o,
    output logic          ren_rd_valid_o,
    output logic [PW-1:0] ren_rd_p_o,
    output logic [PW-1:0] ren_rd_old_p_o,
    output logic [TW-1:0] ren_br_tag_o,
    input  logic          wb_valid_i,
    input  logic [PW-1:0] wb_preg_i,
    input  logic          cmt_valid_i,
    input  logic [PW-1:0] cmt_old_preg_i,
    input  logic          br_valid_i,
    input  logic [TW-1:0] br_tag_i,
    input  logic          br_mispredict_i
);
    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FIW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int unsigned CW       = $clog2(FL_DEPTH + 1);
    localparam int unsigned KW       = TW + 1;
    localparam logic [PHYS_REGS-1:0] RDY_RST =
        {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

    // Free-list pointers carry a wrap bit above the slot index.
    typedef logic [FIW:0] fptr_t;

    function automatic fptr_t fptr_inc(input fptr_t p);
        if (p[FIW-1:0] == FIW'(FL_DEPTH - 1)) begin
            return {~p[FIW], {FIW{1'b0}}};
        end
        return p + fptr_t'(1);
    endfunction

    logic [PW-1:0]        rat_q [ARCH_REGS];
    logic [PW-1:0]        rat_d [ARCH_REGS];
    logic [PW-1:0]        fl_q [FL_DEPTH];
    fptr_t                fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
    logic [CW-1:0]        fl_count_q, fl_count_d, fl_diff;
    logic [PHYS_REGS-1:0] rdy_q, rdy_d;
    logic [PW-1:0]        ckpt_rat_q [NUM_CKPT][ARCH_REGS];
    fptr_t                ckpt_fh_q [NUM_CKPT];
    logic [TW-1:0]        ckpt_head_q, ckpt_head_d, ckpt_tail_q, ckpt_tail_d;
    logic [KW-1:0]        ckpt_count_q, ckpt_count_d;

    logic alloc_needed, mispredict, hit, do_alloc, do_ckpt;

    always_comb begin
        alloc_needed = dec_rd_valid_i && (dec_rd_i != '0);
        mispredict   = br_valid_i && br_mispredict_i;
        hit          = br_valid_i && !br_mispredict_i;
        dec_ready_o  = !(alloc_needed && (fl_count_q == '0)) &&
                       !(dec_is_branch_i && (ckpt_count_q == KW'(NUM_CKPT))) &&
                       !mispredict;
        ren_valid_o  = dec_valid_i && dec_ready_o;
        do_alloc     = ren_valid_o && alloc_needed;
        do_ckpt      = ren_valid_o && dec_is_branch_i;
    end

    // RAT[0] is never written, so x0 sources resolve to p0 naturally.
    always_comb begin
        ren_rs1_p_o    = dec_rs1_valid_i ? rat_q[dec_rs1_i] : '0;
        ren_rs2_p_o    = dec_rs2_valid_i ? rat_q[dec_rs2_i] : '0;
        ren_rs1_rdy_o  = (ren_rs1_p_o == '0) || rdy_q[ren_rs1_p_o] ||
                         (wb_valid_i && (wb_preg_i == ren_rs1_p_o));
        ren_rs2_rdy_o  = (ren_rs2_p_o == '0) || rdy_q[ren_rs2_p_o] ||
                         (wb_valid_i && (wb_preg_i == ren_rs2_p_o));
        ren_rd_valid_o = do_alloc;
        ren_rd_p_o     = fl_q[fl_head_q[FIW-1:0]];
        ren_rd_old_p_o = rat_q[dec_rd_i];
        ren_br_tag_o   = ckpt_tail_q;
    end

    always_comb begin
        rat_d = rat_q;
        if (mispredict) begin
            rat_d = ckpt_rat_q[br_tag_i];
        end else if (do_alloc) begin
            rat_d[dec_rd_i] = ren_rd_p_o;
        end

        rdy_d = rdy_q;
        if (do_alloc) rdy_d[ren_rd_p_o] = 1'b0;
        if (wb_valid_i) rdy_d[wb_preg_i] = 1'b1;
    end

    always_comb begin
        fl_tail_d = cmt_valid_i ? fptr_inc(fl_tail_q) : fl_tail_q;
        if (mispredict) begin
            fl_head_d = ckpt_fh_q[br_tag_i];
        end else if (do_alloc) begin
            fl_head_d = fptr_inc(fl_head_q);
        end else begin
            fl_head_d = fl_head_q;
        end

        // Occupancy between restored head and (post-push) tail.
        if (fl_tail_d[FIW-1:0] >= fl_head_d[FIW-1:0]) begin
            fl_diff = CW'(fl_tail_d[FIW-1:0]) - CW'(fl_head_d[FIW-1:0]);
        end else begin
            fl_diff = CW'(fl_tail_d[FIW-1:0]) + CW'(FL_DEPTH) - CW'(fl_head_d[FIW-1:0]);
        end
        if ((fl_tail_d[FIW-1:0] == fl_head_d[FIW-1:0]) && (fl_tail_d[FIW] != fl_head_d[FIW])) begin
            fl_diff = CW'(FL_DEPTH);
        end

        if (mispredict) begin
            fl_count_d = fl_diff;
        end else begin
            fl_count_d = fl_count_q + CW'(cmt_valid_i) - CW'(do_alloc);
        end
    end

    // A mispredict consumes the resolving checkpoint and drops all younger ones.
    always_comb begin
        if (mispredict) begin
            ckpt_head_d  = br_tag_i + TW'(1);
            ckpt_tail_d  = br_tag_i + TW'(1);
            ckpt_count_d = {1'b0, ckpt_tail_d - ckpt_head_d};
        end else begin
            ckpt_head_d  = hit ? ckpt_head_q + TW'(1) : ckpt_head_q;
            ckpt_tail_d  = do_ckpt ? ckpt_tail_q + TW'(1) : ckpt_tail_q;
            ckpt_count_d = ckpt_count_q + KW'(do_ckpt) - KW'(hit);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PW'(i);
            for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(ARCH_REGS + i);
            fl_head_q    <= '0;
            fl_tail_q    <= {1'b1, {FIW{1'b0}}};
            fl_count_q   <= CW'(FL_DEPTH);
            rdy_q        <= RDY_RST;
            ckpt_head_q  <= '0;
            ckpt_tail_q  <= '0;
            ckpt_count_q <= '0;
        end else begin
            rat_q <= rat_d;
            if (cmt_valid_i) fl_q[fl_tail_q[FIW-1:0]] <= cmt_old_preg_i;
            fl_head_q    <= fl_head_d;
            fl_tail_q    <= fl_tail_d;
            fl_count_q   <= fl_count_d;
            rdy_q        <= rdy_d;
            ckpt_head_q  <= ckpt_head_d;
            ckpt_tail_q  <= ckpt_tail_d;
            ckpt_count_q <= ckpt_count_d;
        end
    end

    // Checkpoint payload is only meaningful while live, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_ckpt) begin
            ckpt_rat_q[ckpt_tail_q] <= rat_d;
            ckpt_fh_q[ckpt_tail_q]  <= fl_head_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmt_valid_i |-> (fl_count_q != CW'(FL_DEPTH)));
    a_no_resolve_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        br_valid_i |-> (ckpt_count_q != '0));

endmodule

// File: tb/tb_rename_ckpt.sv
// Directed bench for rename_ckpt: rename, bypass, free-list wrap, x0 handling,
// checkpoint recovery, checkpoint stack full/release and simultaneous updates.
module tb_rename_ckpt;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_ready, rs1_v, rs2_v, rd_v, is_br;
    logic [4:0] rs1, rs2, rd;
    logic       ren_valid, rs1_rdy, rs2_rdy, rd_valid;
    logic [5:0] rs1_p, rs2_p, rd_p, rd_old_p;
    logic [1:0] br_tag_o;
    logic       wb_valid, cmt_valid, br_valid, br_mis;
    logic [5:0] wb_preg, cmt_old;
    logic [1:0] br_tag;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    rename_ckpt dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .dec_valid_i     (dec_valid),
        .dec_ready_o     (dec_ready),
        .dec_rs1_valid_i (rs1_v),
        .dec_rs2_valid_i (rs2_v),
        .dec_rs1_i       (rs1),
        .dec_rs2_i       (rs2),
        .dec_rd_valid_i  (rd_v),
        .dec_rd_i        (rd),
        .dec_is_branch_i (is_br),
        .ren_valid_o     (ren_valid),
        .ren_rs1_p_o     (rs1_p),
        .ren_rs2_p_o     (rs2_p),
        .ren_rs1_rdy_o   (rs1_rdy),
        .ren_rs2_rdy_o   (rs2_rdy),
        .ren_rd_valid_o  (rd_valid),
        .ren_rd_p_o      (rd_p),
        .ren_rd_old_p_o  (rd_old_p),
        .ren_br_tag_o    (br_tag_o),
        .wb_valid_i      (wb_valid),
        .wb_preg_i       (wb_preg),
        .cmt_valid_i     (cmt_valid),
        .cmt_old_preg_i  (cmt_old),
        .br_valid_i      (br_valid),
        .br_tag_i        (br_tag),
        .br_mispredict_i (br_mis)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 1'b0; rs1_v = 1'b0; rs2_v = 1'b0; rd_v = 1'b0; is_br = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        wb_valid = 1'b0; wb_preg = '0; cmt_valid = 1'b0; cmt_old = '0;
        br_valid = 1'b0; br_mis = 1'b0; br_tag = '0;
    endtask

    task automatic ren(input logic [4:0] s1, input logic [4:0] s2, input logic dv,
                       input logic [4:0] d, input logic br);
        dec_valid = 1'b1; rs1_v = 1'b1; rs2_v = 1'b1;
        rs1 = s1; rs2 = s2; rd_v = dv; rd = d; is_br = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check_val("rst_ren_valid", ren_valid, 0);
        check_val("rst_dec_ready", dec_ready, 1);
        rst_n = 1'b1;
        tick();

        // Basic rename, then bypass of a not-yet-ready source.
        ren(5'd5, 5'd0, 1'b1, 5'd7, 1'b0); #1;
        check_val("t1_ready", dec_ready, 1);
        check_val("t1_valid", ren_valid, 1);
        check_val("t1_rs1_p", rs1_p, 5);
        check_val("t1_rs1_rdy", rs1_rdy, 1);
        check_val("t1_rs2_p", rs2_p, 0);
        check_val("t1_rs2_rdy", rs2_rdy, 1);
        check_val("t1_rd_valid", rd_valid, 1);
        check_val("t1_rd_p", rd_p, 32);
        check_val("t1_rd_old", rd_old_p, 7);
        tick();
        ren(5'd7, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check_val("t1_dep_p", rs1_p, 32);
        check_val("t1_dep_rdy", rs1_rdy, 0);
        check_val("t1_no_alloc", rd_valid, 0);
        wb_valid = 1'b1; wb_preg = 6'd32; #1;
        check_val("t1_bypass", rs1_rdy, 1);
        tick();
        ren(5'd7, 5'd0, 1'b0, 5'd0, 1'b0); #1;
        check_val("t1_wb_written", rs1_rdy, 1);

        // Asynchronous reset in mid-operation restores the identity map.
        rst_n = 1'b0; #1;
        check_val("rst_rat", rs1_p, 7);
        check_val("rst_rdy", rs1_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Drain the free list, stall, then refill with one commit.
        for (int i = 0; i < 32; i++) begin
            ren(5'd0, 5'd0, 1'b1, 5'(i % 31 + 1), 1'b0); #1;
            check_val("t2_alloc", rd_p, 32 + i);
            tick();
        end
        ren(5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        cmt_valid = 1'b1; cmt_old = 6'd7; #1;
        check_val("t2_empty_ready", dec_ready, 0);
        check_val("t2_empty_valid", ren_valid, 0);
        tick();
        ren(5'd0, 5'd0, 1'b1, 5'd9, 1'b0); #1;
        check_val("t2_refill_ready", dec_ready, 1);
        check_val("t2_wrap_p", rd_p, 7);
        tick();

        // rd = x0 needs no free entry.
        ren(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); #1;
        check_val("t3_x0_ready", dec_ready, 1);
        check_val("t3_x0_rd_valid", rd_valid, 0);
        check_val("t3_x0_src", rs1_p, 0);
        tick();
        ren(5'd0, 5'd0, 1'b1, 5'd10, 1'b0); #1;
        check_val("t3_still_empty", dec_ready, 0);
        tick();

        // Checkpoint and mispredict recovery.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        ren(5'd0, 5'd0, 1'b1, 5'd3, 1'b0); #1;
        check_val("t4_x3_p", rd_p, 32);
        tick();
        ren(5'd0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
        check_val("t4_br_tag", br_tag_o, 0);
        check_val("t4_br_ready", dec_ready, 1);
        tick();
        ren(5'd3, 5'd0, 1'b1, 5'd3, 1'b0); #1;
        check_val("t4_rs_eq_rd", rs1_p, 32);
        check_val("t4_x3_p2", rd_p, 33);
        check_val("t4_x3_old", rd_old_p, 32);
        tick();
        ren(5'd0, 5'd0, 1'b1, 5'd4, 1'b0); #1;
        check_val("t4_x4_p", rd_p, 34);
        tick();
        ren(5'd0, 5'd0, 1'b1, 5'd5, 1'b0);
        br_valid = 1'b1; br_mis = 1'b1; br_tag = 2'd0; #1;
        check_val("t4_mis_block", dec_ready, 0);
        check_val("t4_mis_valid", ren_valid, 0);
        tick();
        ren(5'd3, 5'd4, 1'b1, 5'd6, 1'b0); #1;
        check_val("t4_rat_x3", rs1_p, 32);
        check_val("t4_rat_x4", rs2_p, 4);
        check_val("t4_head_restored", rd_p, 33);
        tick();

        // Checkpoint stack fills after four branches; release frees one slot.
        for (int i = 0; i < 4; i++) begin
            ren(5'd0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
            check_val("t5_br_ready", dec_ready, 1);
            check_val("t5_br_tag", br_tag_o, (i + 1) % 4);
            tick();
        end
        ren(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        br_valid = 1'b1; br_mis = 1'b0; br_tag = 2'd1; #1;
        check_val("t5_full", dec_ready, 0);
        tick();
        ren(5'd0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
        check_val("t5_after_hit", dec_ready, 1);
        check_val("t5_wrap_tag", br_tag_o, 1);
        tick();

        // Commit, writeback and allocation in the same cycle.
        ren(5'd0, 5'd0, 1'b1, 5'd8, 1'b0);
        cmt_valid = 1'b1; cmt_old = 6'd5; wb_valid = 1'b1; wb_preg = 6'd33; #1;
        check_val("t6_rd_p", rd_p, 34);
        check_val("t6_rd_old", rd_old_p, 8);
        tick();
        ren(5'd8, 5'd6, 1'b0, 5'd0, 1'b0); #1;
        check_val("t6_rat_x8", rs1_p, 34);
        check_val("t6_rdy_x8", rs1_rdy, 0);
        check_val("t6_rat_x6", rs2_p, 33);
        check_val("t6_wb_set", rs2_rdy, 1);
        tick();
        for (int k = 0; k < 29; k++) begin
            ren(5'd0, 5'd0, 1'b1, 5'(k % 31 + 1), 1'b0); #1;
            check_val("t6_alloc", rd_p, 35 + k);
            tick();
        end
        ren(5'd0, 5'd0, 1'b1, 5'd2, 1'b0); #1;
        check_val("t6_pushed_entry", rd_p, 5);
        check_val("t6_last_ready", dec_ready, 1);
        tick();
        ren(5'd0, 5'd0, 1'b1, 5'd2, 1'b0); #1;
        check_val("t6_count_kept", dec_ready, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
